// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round count, FSM encoding, S-box ROM and the
// byte-level helpers (xtime, ShiftRows, MixColumns) used by the datapath.
package aes_pkg;

    localparam int unsigned NR     = 10;
    localparam int unsigned BLK_W  = 128;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned RND_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_e;

    // Block viewed as 16 bytes; element 0 is s(0,0) in bits [127:120].
    typedef logic [0:15][7:0] blk_t;
    // Block viewed as four columns/words; element 0 is w0 in bits [127:96].
    typedef logic [0:3][WORD_W-1:0] words_t;

    // S-box table; entry 0x00 sits in the top byte.
    localparam logic [2047:0] SBOX_ROM = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry x lives at bit offset (255-x)*8, i.e. {~x, 3'b000}.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_ROM[{~x, 3'b000} +: 8];
    endfunction

    // GF(2^8) doubling modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Row r rotated left by r; byte index is 4*col + row.
    function automatic blk_t shift_rows(input blk_t s);
        blk_t o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[4*c + r] = s[4*((c + r) % 4) + r];
            end
        end
        return o;
    endfunction

    // One MixColumns column; byte [31:24] is row 0.
    function automatic logic [WORD_W-1:0] mix_col(input logic [WORD_W-1:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

endpackage

// File: rtl/aes_round.sv
// Combinational AES encryption round.
//   state_in  : current state
//   rk        : round key for this round
//   last      : final round, MixColumns bypassed
//   state_out : SubBytes -> ShiftRows -> (MixColumns) -> AddRoundKey
module aes_round
    import aes_pkg::*;
(
    input  logic [BLK_W-1:0] state_in,
    input  logic [BLK_W-1:0] rk,
    input  logic             last,
    output logic [BLK_W-1:0] state_out
);

    blk_t   s_in;
    blk_t   s_sub;
    blk_t   s_shift;
    words_t s_mix;

    assign s_in = state_in;

    // 16 parallel S-boxes
    for (genvar i = 0; i < 16; i++) begin : g_sbox
        assign s_sub[i] = sbox(s_in[i]);
    end

    assign s_shift = shift_rows(s_sub);

    for (genvar c = 0; c < 4; c++) begin : g_mix
        assign s_mix[c] = mix_col({s_shift[4*c], s_shift[4*c+1],
                                   s_shift[4*c+2], s_shift[4*c+3]});
    end

    assign state_out = (last ? BLK_W'(s_shift) : BLK_W'(s_mix)) ^ rk;

endmodule

// File: rtl/aes128_enc_seq.sv
// Iterative AES-128 encryptor: one round per clock, round keys expanded on
// the fly, valid/ready on both sides.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : plaintext/key handshake
//   in_pt, in_key       : 128-bit plaintext and key (FIPS-197 byte order)
//   out_valid/out_ready : ciphertext handshake
//   out_ct              : ciphertext, meaningful while out_valid
//   busy                : block is in RUN or DONE
module aes128_enc_seq
    import aes_pkg::*;
#(
    parameter bit ZERO_ON_IDLE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] in_pt,
    input  logic [BLK_W-1:0] in_key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_ct,
    output logic             busy
);

    fsm_e             fsm_q;
    logic [BLK_W-1:0] state_q;
    logic [BLK_W-1:0] rk_q;
    logic [7:0]       rcon_q;
    logic [RND_W-1:0] rnd_q;

    words_t            rk_w;
    logic [WORD_W-1:0] rot_w, sub_w;
    logic [WORD_W-1:0] w0_n, w1_n, w2_n, w3_n;
    logic [BLK_W-1:0]  rk_next;
    logic [BLK_W-1:0]  round_out;
    logic              last_rnd;

    // Next round key from the current one
    assign rk_w    = rk_q;
    assign rot_w   = {rk_w[3][23:0], rk_w[3][31:24]};
    assign sub_w   = {sbox(rot_w[31:24]), sbox(rot_w[23:16]),
                      sbox(rot_w[15:8]),  sbox(rot_w[7:0])};
    assign w0_n    = rk_w[0] ^ sub_w ^ {rcon_q, 24'h0};
    assign w1_n    = rk_w[1] ^ w0_n;
    assign w2_n    = rk_w[2] ^ w1_n;
    assign w3_n    = rk_w[3] ^ w2_n;
    assign rk_next = {w0_n, w1_n, w2_n, w3_n};

    assign last_rnd = (rnd_q == RND_W'(NR));

    aes_round u_round (
        .state_in  (state_q),
        .rk        (rk_next),
        .last      (last_rnd),
        .state_out (round_out)
    );

    // The ciphertext is the state register itself once in DONE.
    assign out_ct = state_q;

    // Control FSM, datapath registers and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q     <= IDLE;
            state_q   <= '0;
            rk_q      <= '0;
            rcon_q    <= '0;
            rnd_q     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q  <= in_pt ^ in_key;
                        rk_q     <= in_key;
                        rcon_q   <= 8'h01;
                        rnd_q    <= RND_W'(1);
                        fsm_q    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    state_q <= round_out;
                    rk_q    <= rk_next;
                    rcon_q  <= xtime(rcon_q);
                    if (last_rnd) begin
                        fsm_q     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        rnd_q <= rnd_q + RND_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm_q     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        rnd_q     <= '0;
                        if (ZERO_ON_IDLE) begin
                            state_q <= '0;
                            rk_q    <= '0;
                            rcon_q  <= '0;
                        end
                    end
                end
                default: begin
                    fsm_q     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_enc_seq.sv
// Scoreboard bench for aes128_enc_seq against a byte-array AES-128 model.
module tb_aes128_enc_seq;

    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready, in_ready_k;
    logic [127:0] in_pt, in_key;
    logic         out_valid, out_valid_k;
    logic         out_ready;
    logic [127:0] out_ct, out_ct_k;
    logic         busy, busy_k;

    aes128_enc_seq #(.ZERO_ON_IDLE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_pt(in_pt), .in_key(in_key), .out_valid(out_valid),
        .out_ready(out_ready), .out_ct(out_ct), .busy(busy)
    );

    aes128_enc_seq #(.ZERO_ON_IDLE(1'b0)) dut_keep (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_k),
        .in_pt(in_pt), .in_key(in_key), .out_valid(out_valid_k),
        .out_ready(out_ready), .out_ct(out_ct_k), .busy(busy_k)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errs   = 0;
    int checks = 0;

    typedef struct {
        logic [127:0] ct;
        logic [127:0] rk;
        int           acc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   last_acc;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] sb_tab [256];

    // Carry-less product reduced modulo 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p ^= 15'(a) << i;
        for (int i = 14; i >= 8; i--) if (p[i]) p ^= 15'(9'h11b) << (i - 8);
        return p[7:0];
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    task automatic build_sbox();
        logic [7:0]  inv;
        logic [15:0] d;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            d = {inv, inv};
            sb_tab[x] = inv ^ d[14:7] ^ d[13:6] ^ d[12:5] ^ d[11:4] ^ 8'h63;
        end
    endtask

    function automatic logic [7:0] kbyte(input logic [31:0] w, input int r);
        return 8'(w >> (24 - 8*r));
    endfunction

    task automatic ref_encrypt(input logic [127:0] pt, input logic [127:0] key,
                               output logic [127:0] ct, output logic [127:0] last_rk);
        logic [0:15][7:0] s, t, pb;
        logic [0:3][31:0] kw;
        logic [31:0]      w [44];
        logic [31:0]      tmp;
        logic [7:0]       rc;
        logic [7:0]       a [4];
        kw = key;
        for (int i = 0; i < 4; i++) w[i] = kw[i];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb_tab[tmp[23:16]], sb_tab[tmp[15:8]], sb_tab[tmp[7:0]],
                       sb_tab[tmp[31:24]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        pb = pt;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[4*c+r] = pb[4*c+r] ^ kbyte(w[c], r);
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) s[i] = sb_tab[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 4; r++) a[r] = t[4*c+r];
                for (int r = 0; r < 4; r++) begin
                    if (rnd < 10)
                        s[4*c+r] = gmul(8'h02, a[r]) ^ gmul(8'h03, a[(r+1)%4])
                                 ^ a[(r+2)%4] ^ a[(r+3)%4];
                    else
                        s[4*c+r] = a[r];
                    s[4*c+r] ^= kbyte(w[4*rnd+c], r);
                end
            end
        end
        ct      = s;
        last_rk = {w[40], w[41], w[42], w[43]};
    endtask

    // ---------------- monitor ----------------
    logic         prev_valid = 1'b0;
    logic         zpend      = 1'b0;
    logic [127:0] zct, zrk;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            zpend      = 1'b0;
        end else begin
            if (zpend) begin
                zpend = 1'b0;
                check("zero_state", dut.state_q, 128'h0);
                check("zero_rk", dut.rk_q, 128'h0);
                check("keep_state", dut_keep.state_q, zct);
                check("keep_rk", dut_keep.rk_q, zrk);
            end
            if (out_valid && !prev_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL unexpected_out: out_valid with empty scoreboard, ct %h", out_ct);
                end else begin
                    check("latency", 128'(cyc - sb_q[0].acc), 128'd10);
                end
            end
            if (out_valid && out_ready && sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                check("out_ct", out_ct, mon_e.ct);
                check("out_ct_keep", out_ct_k, mon_e.ct);
                check("out_valid_keep", 128'(out_valid_k), 128'd1);
                zpend = 1'b1;
                zct   = mon_e.ct;
                zrk   = mon_e.rk;
            end
            prev_valid = out_valid;
        end
    end

    // ---------------- stimulus ----------------
    task automatic offer(input logic [127:0] pt, input logic [127:0] key,
                         input logic [127:0] exp_ct, input logic [127:0] exp_rk,
                         input bit keep_valid);
        bit ok;
        exp_t e;
        ok = 1'b0;
        in_pt    = pt;
        in_key   = key;
        in_valid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errs++;
            $display("FAIL accept_timeout: in_ready stayed 0 for 100 cycles");
        end else begin
            e.ct   = exp_ct;
            e.rk   = exp_rk;
            e.acc  = cyc + 1;
            last_acc = e.acc;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (!keep_valid) in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && in_ready) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errs++;
            $display("FAIL drain_timeout: %0d results outstanding", sb_q.size());
            sb_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (out_valid) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errs++;
            $display("FAIL out_valid_timeout: no out_valid in 50 cycles");
        end
    endtask

    logic [127:0] c1_ct, c1_rk, b_ct, b_rk, r_pt, r_key, r_ct, r_rk, held;
    int           t1;
    bit           got;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_pt     = '0;
        in_key    = '0;
        out_ready = 1'b1;
        build_sbox();
        ref_encrypt(C1_PT, C1_KEY, c1_ct, c1_rk);
        ref_encrypt(B_PT, B_KEY, b_ct, b_rk);

        // reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_out_ct", out_ct, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // C.1 known answer
        offer(C1_PT, C1_KEY, C1_CT, c1_rk, 1'b0);
        drain();

        // App. B with 20 cycles of backpressure and ignored in_valid pulses
        out_ready = 1'b0;
        offer(B_PT, B_KEY, B_CT, b_rk, 1'b0);
        wait_out_valid(got);
        held = out_ct;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            in_valid = i[0];
            in_pt    = {$urandom(), $urandom(), $urandom(), $urandom()};
            in_key   = {$urandom(), $urandom(), $urandom(), $urandom()};
            @(negedge clk);
            check("bp_out_ct_stable", out_ct, held);
            check("bp_in_ready_low", 128'(in_ready), 128'd0);
            check("bp_out_valid_held", 128'(out_valid), 128'd1);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // back-to-back with in_valid held high
        offer(C1_PT, C1_KEY, C1_CT, c1_rk, 1'b1);
        t1 = last_acc;
        offer(B_PT, B_KEY, B_CT, b_rk, 1'b1);
        in_valid = 1'b0;
        check("b2b_spacing", 128'(last_acc - t1), 128'd12);
        drain();

        // reset in the middle of RUN
        offer(C1_PT, C1_KEY, C1_CT, c1_rk, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        check("mid_busy_before", 128'(busy), 128'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 128'(out_valid), 128'd0);
        check("mid_rst_busy", 128'(busy), 128'd0);
        check("mid_rst_in_ready", 128'(in_ready), 128'd1);
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        offer(C1_PT, C1_KEY, C1_CT, c1_rk, 1'b0);
        drain();

        // randomized blocks with random idle gaps
        for (int n = 0; n < 8; n++) begin
            r_pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
            r_key = {$urandom(), $urandom(), $urandom(), $urandom()};
            ref_encrypt(r_pt, r_key, r_ct, r_rk);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            offer(r_pt, r_key, r_ct, r_rk, 1'b0);
        end
        drain();
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
